// File: rtl/rng_sched_pkg.sv
// Shared constants for the RNG request scheduler: byte width, parameter defaults
// and FSM state encodings.
package rng_sched_pkg;

  localparam int BYTE_W               = 8;
  localparam int NUM_REQ_DEF          = 4;
  localparam int BYTES_PER_WORD_DEF   = 4;
  localparam int WARMUP_BYTES_DEF     = 16;
  localparam int REPEAT_LIMIT_DEF     = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WARMUP  = 3'd1;
  localparam state_t ST_ARB     = 3'd2;
  localparam state_t ST_COLLECT = 3'd3;
  localparam state_t ST_DELIVER = 3'd4;
  localparam state_t ST_FAULT   = 3'd5;

endpackage

// File: rtl/rng_request_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] N = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= N) pos = pos - N;
      if (!any && req[pos[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = pos[IDX_W-1:0];
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/rng_request_scheduler.sv
// Shares the filter-bank byte stream among requesters: warm-up discard, round-robin
// grant, word packing and valid/ack delivery. Optional health test: RNG_REPEAT_CHECK_EN.
module rng_request_scheduler
  import rng_sched_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int WARMUP_BYTES   = WARMUP_BYTES_DEF,
  parameter int REPEAT_LIMIT   = REPEAT_LIMIT_DEF
) (
  input  logic                             low_Freq_Clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [BYTE_W-1:0]                rnd_byte,
  input  logic [NUM_REQ-1:0]               req,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] rnd_word,
  output logic                             word_valid,
  input  logic                             word_ack,
  output logic                             ready,
  output logic                             health_fail
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [7:0]       WARM_LAST = 8'(WARMUP_BYTES - 1);
  localparam logic [BC_W-1:0]  BYTE_LAST = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  state_t           state;
  logic [7:0]       warm_cnt;
  logic [BC_W-1:0]  byte_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               fault_trip;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef RNG_REPEAT_CHECK_EN
  localparam logic [7:0] REP_LIMIT = 8'(REPEAT_LIMIT);

  logic [BYTE_W-1:0] prev_byte;
  logic [7:0]        rep_cnt;
  logic [7:0]        rep_next;
  logic              fail_q;

  // Run length of identical bytes, including the current one; zero while idle.
  always_comb begin
    rep_next = 8'd1;
    if (rep_cnt != 8'd0 && rnd_byte == prev_byte)
      rep_next = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
  end

  assign fault_trip  = (state != ST_IDLE) && (state != ST_FAULT) && (rep_next == REP_LIMIT);
  assign health_fail = fail_q;

  always_ff @(posedge low_Freq_Clk or negedge reset) begin
    if (!reset) begin
      prev_byte <= '0;
      rep_cnt   <= '0;
      fail_q    <= 1'b0;
    end else begin
      prev_byte <= rnd_byte;
      rep_cnt   <= (state == ST_IDLE) ? 8'd0 : rep_next;
      if (fault_trip) fail_q <= 1'b1;
    end
  end
`else
  assign fault_trip  = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge low_Freq_Clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      warm_cnt   <= '0;
      byte_cnt   <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      gnt        <= '0;
      rnd_word   <= '0;
      word_valid <= 1'b0;
      ready      <= 1'b0;
    end else if (fault_trip) begin
      state      <= ST_FAULT;
      gnt        <= '0;
      word_valid <= 1'b0;
      ready      <= 1'b0;
    end else if (state != ST_FAULT && !enable) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      word_valid <= 1'b0;
      ready      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_WARMUP;
          warm_cnt <= '0;
        end
        ST_WARMUP: begin
          warm_cnt <= warm_cnt + 8'd1;
          if (warm_cnt == WARM_LAST) begin
            state <= ST_ARB;
            ready <= 1'b1;
          end
        end
        ST_ARB: begin
          if (arb_any) begin
            gnt      <= arb_gnt;
            gnt_idx  <= arb_idx;
            byte_cnt <= '0;
            state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          for (int s = 0; s < BYTES_PER_WORD; s++)
            if (byte_cnt == BC_W'(s)) rnd_word[s*BYTE_W +: BYTE_W] <= rnd_byte;
          byte_cnt <= byte_cnt + BC_W'(1);
          if (byte_cnt == BYTE_LAST) begin
            state      <= ST_DELIVER;
            word_valid <= 1'b1;
          end
        end
        ST_DELIVER: begin
          if (word_ack) begin
            word_valid <= 1'b0;
            gnt        <= '0;
            rr_ptr     <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
            state      <= ST_ARB;
          end
        end
        default: begin
          // FAULT is only left through reset.
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_request_scheduler.sv
// Directed bench for rng_request_scheduler with default parameters; the health-test
// section runs only when RNG_REPEAT_CHECK_EN is defined.
module tb_rng_request_scheduler;

  logic        low_Freq_Clk;
  logic        reset;
  logic        enable;
  logic [7:0]  rnd_byte;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rnd_word;
  logic        word_valid;
  logic        word_ack;
  logic        ready;
  logic        health_fail;

  int checks = 0;
  int errors = 0;
  logic hold_byte = 1'b0;

  rng_request_scheduler dut (
    .low_Freq_Clk (low_Freq_Clk),
    .reset        (reset),
    .enable       (enable),
    .rnd_byte     (rnd_byte),
    .req          (req),
    .gnt          (gnt),
    .rnd_word     (rnd_word),
    .word_valid   (word_valid),
    .word_ack     (word_ack),
    .ready        (ready),
    .health_fail  (health_fail)
  );

  initial low_Freq_Clk = 1'b0;
  always #5 low_Freq_Clk = ~low_Freq_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later; free-running bytes stay distinct.
  task automatic cyc();
    @(posedge low_Freq_Clk);
    #1;
    if (!hold_byte) rnd_byte = rnd_byte + 8'd1;
  endtask

  task automatic rr_word(input string tag, input logic [3:0] exp_gnt);
    cyc();
    chk({tag, "_gnt"}, {28'd0, gnt}, {28'd0, exp_gnt});
    repeat (3) cyc();
    chk({tag, "_notyet"}, {31'd0, word_valid}, 32'd0);
    cyc();
    chk({tag, "_valid"}, {31'd0, word_valid}, 32'd1);
    chk({tag, "_gnt_dlv"}, {28'd0, gnt}, {28'd0, exp_gnt});
    word_ack = 1'b1;
    cyc();
    word_ack = 1'b0;
    chk({tag, "_acked"}, {27'd0, word_valid, gnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; rnd_byte = 8'h00; req = 4'b0000; word_ack = 1'b0;
    repeat (2) cyc();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_word", rnd_word, 32'd0);
    chk("rst_flags", {29'd0, word_valid, ready, health_fail}, 32'd0);

    // Warm-up: enable sampled at the next edge, ready 16 edges later.
    reset = 1'b1; enable = 1'b1; req = 4'b0001;
    cyc();
    chk("warm_start", {31'd0, ready}, 32'd0);
    repeat (15) cyc();
    chk("warm_15", {31'd0, ready}, 32'd0);
    cyc();
    chk("warm_ready", {31'd0, ready}, 32'd1);
    chk("warm_nognt", {28'd0, gnt}, 32'd0);
    cyc();
    chk("first_gnt", {28'd0, gnt}, 32'h1);

    // Packing: four known bytes, first byte in the LSBs.
    hold_byte = 1'b1;
    rnd_byte = 8'h11; cyc();
    rnd_byte = 8'h22; cyc();
    rnd_byte = 8'h33; cyc();
    chk("pack_notyet", {31'd0, word_valid}, 32'd0);
    rnd_byte = 8'h44; cyc();
    chk("pack_valid", {31'd0, word_valid}, 32'd1);
    chk("pack_word", rnd_word, 32'h44332211);
    hold_byte = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_valid", {31'd0, word_valid}, 32'd1);
      chk("hold_word", rnd_word, 32'h44332211);
      chk("hold_gnt", {28'd0, gnt}, 32'h1);
    end
    word_ack = 1'b1;
    cyc();
    word_ack = 1'b0;
    chk("ack_clear", {27'd0, word_valid, gnt}, 32'd0);
    chk("ack_ready", {31'd0, ready}, 32'd1);

    // Round-robin continues from requester 1.
    req = 4'b1111;
    rr_word("rr1", 4'b0010);
    rr_word("rr2", 4'b0100);
    rr_word("rr3", 4'b1000);
    rr_word("rr0", 4'b0001);

    // Requester 2 alone, drops req mid-collect; word still delivered to it.
    req = 4'b0100;
    cyc();
    chk("drop_gnt", {28'd0, gnt}, 32'h4);
    cyc();
    req = 4'b0000;
    repeat (3) cyc();
    chk("drop_valid", {31'd0, word_valid}, 32'd1);
    chk("drop_gnt_dlv", {28'd0, gnt}, 32'h4);
    word_ack = 1'b1;
    cyc();
    word_ack = 1'b0;
    repeat (3) cyc();
    chk("idle_arb", {27'd0, word_valid, gnt}, 32'd0);
    word_ack = 1'b1;
    cyc();
    word_ack = 1'b0;
    cyc();
    chk("stray_ack", {27'd0, word_valid, gnt}, 32'd0);
    chk("stray_ready", {31'd0, ready}, 32'd1);

    // Pointer is 3; only requester 0 asks, so the scan wraps to it.
    req = 4'b0001;
    cyc();
    chk("wrap_gnt", {28'd0, gnt}, 32'h1);
    hold_byte = 1'b1;
    rnd_byte = 8'hDE; cyc();
    rnd_byte = 8'hAD; cyc();
    rnd_byte = 8'hBE; cyc();
    rnd_byte = 8'hEF; cyc();
    hold_byte = 1'b0;
    chk("abort_word", rnd_word, 32'hEFBEADDE);
    chk("abort_valid", {31'd0, word_valid}, 32'd1);
    enable = 1'b0;
    cyc();
    chk("dis_flags", {26'd0, ready, word_valid, gnt}, 32'd0);
    chk("dis_word_kept", rnd_word, 32'hEFBEADDE);

    // Re-enable repeats the full warm-up.
    enable = 1'b1;
    cyc();
    repeat (15) cyc();
    chk("rewarm_15", {31'd0, ready}, 32'd0);
    cyc();
    chk("rewarm_ready", {31'd0, ready}, 32'd1);
    cyc();
    chk("rewarm_gnt", {28'd0, gnt}, 32'h1);
    repeat (2) cyc();

    // Asynchronous reset mid-collect, checked before any further edge.
    #2 reset = 1'b0;
    #1;
    chk("arst_gnt", {28'd0, gnt}, 32'd0);
    chk("arst_word", rnd_word, 32'd0);
    chk("arst_flags", {29'd0, word_valid, ready, health_fail}, 32'd0);

`ifdef RNG_REPEAT_CHECK_EN
    // Eight equal bytes: four in ARB, one on the grant edge, three in COLLECT.
    cyc();
    reset = 1'b1; enable = 1'b1; req = 4'b0000;
    repeat (17) cyc();
    chk("hc_ready", {31'd0, ready}, 32'd1);
    hold_byte = 1'b1;
    rnd_byte = 8'h5A; cyc();
    rnd_byte = 8'hA5;
    repeat (4) cyc();
    req = 4'b0001;
    cyc();
    chk("hc_gnt", {28'd0, gnt}, 32'h1);
    repeat (2) cyc();
    chk("hc_pre_fail", {31'd0, health_fail}, 32'd0);
    cyc();
    chk("hc_fail", {31'd0, health_fail}, 32'd1);
    chk("hc_outs", {26'd0, ready, word_valid, gnt}, 32'd0);
    hold_byte = 1'b0;
    word_ack = 1'b1;
    repeat (6) cyc();
    word_ack = 1'b0;
    enable = 1'b0; cyc(); enable = 1'b1;
    repeat (20) cyc();
    chk("hc_sticky", {26'd0, ready, word_valid, gnt}, 32'd0);
    chk("hc_sticky_flag", {31'd0, health_fail}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("hc_reset", {31'd0, health_fail}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
